// File: rtl/fetch_queue.sv
// Instruction-fetch front end: fetch-PC sequencer, synchronous-read imem request port
// and a DEPTH-entry {inst, pc} queue handed to decode with valid/ready.
module fetch_queue #(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [INST_W-1:0]        imem_rdata,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     inst_valid,
    output logic [INST_W-1:0]        inst,
    output logic [ADDR_W-1:0]        inst_pc,
    input  logic                     inst_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fpc_reg;
    logic              infl_reg;
    logic [ADDR_W-1:0] infl_pc_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic [INST_W-1:0] inst_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];

    logic              pop;
    logic              push;
    logic [CNT_W:0]    space;
    logic              unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    // A slot is reserved for the in-flight fetch, so a push can never overflow.
    assign pop      = inst_valid & inst_ready;
    assign space    = DEPTH_W + (CNT_W + 1)'(pop)
                      - {1'b0, count_reg} - (CNT_W + 1)'(infl_reg);
    assign imem_req = ~reset & ~redirect & (space != '0);
    assign push     = infl_reg & ~redirect;

    assign imem_addr  = fpc_reg;
    assign inst_valid = (count_reg != '0);
    assign inst       = inst_q[rd_ptr_reg];
    assign inst_pc    = pc_q[rd_ptr_reg];
    assign occupancy  = count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_reg    <= RESET_PC;
            infl_reg   <= 1'b0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (redirect) begin
            fpc_reg    <= {redirect_pc[ADDR_W-1:2], 2'b00};
            infl_reg   <= 1'b0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (imem_req) begin
                fpc_reg  <= fpc_reg + ADDR_W'(4);
                infl_reg <= 1'b1;
            end else begin
                infl_reg <= 1'b0;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req) begin
            infl_pc_reg <= fpc_reg;
        end
    end

    // Per-entry storage; no reset needed because count gates visibility.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (!reset && push && (wr_ptr_reg == PTR_W'(gi))) begin
                inst_q[gi] <= imem_rdata;
                pc_q[gi]   <= infl_pc_reg;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: two instances (DEPTH 4 at 0x100, DEPTH 2 near the top of memory)
// share stimulus; a queue-level model is compared every cycle, plus literal pins.
module tb_fetch_queue;

    localparam int K_REQ   = 0;
    localparam int K_ADDR  = 1;
    localparam int K_VALID = 2;
    localparam int K_OCC   = 3;
    localparam int K_PC    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        inst_ready;

    int n_cmp = 0;
    int n_bad = 0;

    int          pin_n = 0;
    int          pin_rd = 0;
    int          pin_lane [64];
    int          pin_kind [64];
    logic [63:0] pin_val  [64];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        localparam int          D  = (gi == 0) ? 4 : 2;
        localparam logic [63:0] RP = (gi == 0) ? 64'h100 : 64'hFFFF_FFFF_FFFF_FFF8;

        logic                 req;
        logic [63:0]          addr;
        logic [31:0]          rdata = '0;
        logic                 valid;
        logic [31:0]          inst;
        logic [63:0]          ipc;
        logic [$clog2(D):0]   occ;

        fetch_queue #(.ADDR_W(64), .INST_W(32), .DEPTH(D), .RESET_PC(RP)) dut (
            .clk(clk), .reset(reset),
            .imem_req(req), .imem_addr(addr), .imem_rdata(rdata),
            .redirect(redirect), .redirect_pc(redirect_pc),
            .inst_valid(valid), .inst(inst), .inst_pc(ipc),
            .inst_ready(inst_ready), .occupancy(occ)
        );

        // Instruction memory returns the low word of the address one cycle later.
        always @(posedge clk) begin
            if (req) rdata <= addr[31:0];
        end

        // Model: a plain queue of PCs plus the fetch PC and a pending-fetch flag.
        logic [63:0] mq [$];
        logic        m_ok = 1'b0;
        logic [63:0] m_fpc = '0;
        logic        m_infl = 1'b0;
        logic [63:0] m_infl_pc = '0;
        int          m_size = 0;
        logic [63:0] m_head = '0;

        always @(posedge clk) begin : mdl
            bit mpop;
            int mspace;
            bit mreq;
            mpop   = (mq.size() != 0) && inst_ready;
            mspace = D - mq.size() - int'(m_infl) + int'(mpop);
            mreq   = !reset && !redirect && (mspace > 0);
            if (reset) begin
                mq.delete();
                m_fpc  <= RP;
                m_infl <= 1'b0;
                m_ok   <= 1'b1;
            end else if (redirect) begin
                mq.delete();
                m_fpc  <= redirect_pc & ~64'h3;
                m_infl <= 1'b0;
            end else begin
                if (mpop) void'(mq.pop_front());
                if (m_infl) mq.push_back(m_infl_pc);
                if (mreq) begin
                    m_infl_pc <= m_fpc;
                    m_fpc     <= m_fpc + 64'd4;
                end
                m_infl <= mreq;
            end
            m_size <= mq.size();
            m_head <= (mq.size() != 0) ? mq[0] : 64'h0;
        end
    end

    task automatic chk(input string name, input int lane, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s lane%0d t=%0t: got %h expected %h", name, lane, $time, act, exp);
        end
    endtask

    task automatic cmp_lane(input int k, input int d, input logic m_ok,
                            input logic req, input logic [63:0] addr, input logic valid,
                            input logic [63:0] occ, input logic [31:0] inst,
                            input logic [63:0] pc, input int m_size, input logic m_infl,
                            input logic [63:0] m_fpc, input logic [63:0] m_head);
        bit p;
        int sp;
        if (!m_ok) return;
        p  = (m_size != 0) && inst_ready;
        sp = d - m_size - int'(m_infl) + int'(p);
        chk("req",   k, {63'b0, req}, {63'b0, (!reset && !redirect && sp > 0)});
        chk("addr",  k, addr, m_fpc);
        chk("valid", k, {63'b0, valid}, {63'b0, (m_size != 0)});
        chk("occ",   k, occ, 64'(m_size));
        if (m_size != 0) begin
            chk("pc",   k, pc, m_head);
            chk("inst", k, {32'b0, inst}, {32'b0, m_head[31:0]});
        end
    endtask

    function automatic logic [63:0] act_of(input int lane, input int kind);
        logic [63:0] v;
        v = '0;
        if (lane == 0) begin
            case (kind)
                K_REQ:   v = {63'b0, g_lane[0].req};
                K_ADDR:  v = g_lane[0].addr;
                K_VALID: v = {63'b0, g_lane[0].valid};
                K_OCC:   v = 64'(g_lane[0].occ);
                default: v = g_lane[0].ipc;
            endcase
        end else begin
            case (kind)
                K_REQ:   v = {63'b0, g_lane[1].req};
                K_ADDR:  v = g_lane[1].addr;
                K_VALID: v = {63'b0, g_lane[1].valid};
                K_OCC:   v = 64'(g_lane[1].occ);
                default: v = g_lane[1].ipc;
            endcase
        end
        return v;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            cmp_lane(0, 4, g_lane[0].m_ok, g_lane[0].req, g_lane[0].addr, g_lane[0].valid,
                     64'(g_lane[0].occ), g_lane[0].inst, g_lane[0].ipc, g_lane[0].m_size,
                     g_lane[0].m_infl, g_lane[0].m_fpc, g_lane[0].m_head);
            cmp_lane(1, 2, g_lane[1].m_ok, g_lane[1].req, g_lane[1].addr, g_lane[1].valid,
                     64'(g_lane[1].occ), g_lane[1].inst, g_lane[1].ipc, g_lane[1].m_size,
                     g_lane[1].m_infl, g_lane[1].m_fpc, g_lane[1].m_head);
            for (int i = pin_rd; i < pin_n; i++) begin
                chk($sformatf("pin%0d_kind%0d", i, pin_kind[i]), pin_lane[i],
                    act_of(pin_lane[i], pin_kind[i]), pin_val[i]);
            end
            pin_rd = pin_n;
        end
    end

    task automatic pin(input int lane, input int kind, input logic [63:0] v);
        pin_lane[pin_n] = lane;
        pin_kind[pin_n] = kind;
        pin_val[pin_n]  = v;
        pin_n++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
        tick();
        pin(0, K_REQ, 0); pin(0, K_ADDR, 64'h100); pin(0, K_VALID, 0); pin(0, K_OCC, 0);
        pin(1, K_ADDR, 64'hFFFF_FFFF_FFFF_FFF8);
        tick();
        reset = 1'b0;                                           // c1
        pin(0, K_REQ, 1); pin(0, K_ADDR, 64'h100); pin(1, K_ADDR, 64'hFFFF_FFFF_FFFF_FFF8);
        ticks(2);                                               // c3
        pin(0, K_VALID, 1); pin(0, K_PC, 64'h100); pin(1, K_PC, 64'hFFFF_FFFF_FFFF_FFF8);
        tick();                                                 // c4
        pin(0, K_PC, 64'h104); pin(1, K_PC, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();  pin(1, K_PC, 64'h0);                           // c5
        tick();  pin(1, K_PC, 64'h4);                           // c6
        ticks(2);                                               // c8: backpressure
        inst_ready = 1'b0; pin(0, K_PC, 64'h114);
        ticks(9);                                               // c17
        pin(0, K_OCC, 4); pin(0, K_REQ, 0); pin(1, K_OCC, 2);
        tick();  inst_ready = 1'b1; pin(0, K_PC, 64'h114);      // c18
        tick();  pin(0, K_PC, 64'h118);                         // c19
        ticks(3);                                               // c22: redirect flush
        pin(0, K_OCC, 3); pin(0, K_PC, 64'h124);
        redirect = 1'b1; redirect_pc = 64'h2003;
        tick();  redirect = 1'b0;                               // c23
        pin(0, K_REQ, 1); pin(0, K_ADDR, 64'h2000); pin(0, K_VALID, 0);
        tick();  pin(0, K_VALID, 0);                            // c24
        tick();  pin(0, K_VALID, 1); pin(0, K_PC, 64'h2000);    // c25
        tick();  pin(0, K_PC, 64'h2004);                        // c26
        tick();  inst_ready = 1'b0;                             // c27
        ticks(2);                                               // c29: reset mid-stream
        pin(0, K_OCC, 3); reset = 1'b1; inst_ready = 1'b1;
        tick();  pin(0, K_OCC, 0); pin(0, K_VALID, 0); pin(0, K_REQ, 0);   // c30
        tick();  reset = 1'b0; pin(0, K_REQ, 1); pin(0, K_ADDR, 64'h100);  // c31
        ticks(2); pin(0, K_VALID, 1); pin(0, K_PC, 64'h100);    // c33
        tick();  pin(0, K_PC, 64'h104);                         // c34: redirect with pop
        redirect = 1'b1; redirect_pc = 64'h3000;
        tick();  redirect = 1'b0;                               // c35
        pin(0, K_VALID, 0); pin(0, K_REQ, 1); pin(0, K_ADDR, 64'h3000);
        tick();  pin(0, K_VALID, 0);                            // c36
        tick();  pin(0, K_PC, 64'h3000);                        // c37
        tick();  redirect = 1'b1; redirect_pc = 64'h4000;       // c38: back-to-back
        tick();  redirect_pc = 64'h5008; pin(0, K_REQ, 0);      // c39
        tick();  redirect = 1'b0;                               // c40
        pin(0, K_REQ, 1); pin(0, K_ADDR, 64'h5008); pin(1, K_ADDR, 64'h5008);
        ticks(2); pin(0, K_VALID, 1); pin(0, K_PC, 64'h5008);   // c42
        for (int i = 0; i < 40; i++) begin
            tick();
            inst_ready = 1'($urandom_range(0, 1));
            redirect   = ($urandom_range(0, 9) == 0);
            redirect_pc = {$urandom, $urandom};
        end
        tick();
        redirect = 1'b0;
        ticks(3);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
